// File: rtl/nasti_sram_slave_if.sv
// NASTI (AXI4) channel bundle: AW, W, B, AR and R channels between one master and one slave.
interface nasti_channel #(
  parameter int ADDR_WIDTH = 64,
  parameter int DATA_WIDTH = 64,
  parameter int ID_WIDTH   = 1
);
  logic                    aw_valid;
  logic                    aw_ready;
  logic [ADDR_WIDTH-1:0]   aw_addr;
  logic [7:0]              aw_len;
  logic [2:0]              aw_size;
  logic [1:0]              aw_burst;
  logic [ID_WIDTH-1:0]     aw_id;

  logic                    w_valid;
  logic                    w_ready;
  logic [DATA_WIDTH-1:0]   w_data;
  logic [DATA_WIDTH/8-1:0] w_strb;
  logic                    w_last;

  logic                    b_valid;
  logic                    b_ready;
  logic [ID_WIDTH-1:0]     b_id;
  logic [1:0]              b_resp;

  logic                    ar_valid;
  logic                    ar_ready;
  logic [ADDR_WIDTH-1:0]   ar_addr;
  logic [7:0]              ar_len;
  logic [2:0]              ar_size;
  logic [1:0]              ar_burst;
  logic [ID_WIDTH-1:0]     ar_id;

  logic                    r_valid;
  logic                    r_ready;
  logic [DATA_WIDTH-1:0]   r_data;
  logic                    r_last;
  logic [ID_WIDTH-1:0]     r_id;
  logic [1:0]              r_resp;

  modport slave (
    input  aw_valid, aw_addr, aw_len, aw_size, aw_burst, aw_id,
    output aw_ready,
    input  w_valid, w_data, w_strb, w_last,
    output w_ready,
    output b_valid, b_id, b_resp,
    input  b_ready,
    input  ar_valid, ar_addr, ar_len, ar_size, ar_burst, ar_id,
    output ar_ready,
    output r_valid, r_data, r_last, r_id, r_resp,
    input  r_ready
  );

  modport master (
    output aw_valid, aw_addr, aw_len, aw_size, aw_burst, aw_id,
    input  aw_ready,
    output w_valid, w_data, w_strb, w_last,
    input  w_ready,
    input  b_valid, b_id, b_resp,
    output b_ready,
    output ar_valid, ar_addr, ar_len, ar_size, ar_burst, ar_id,
    input  ar_ready,
    input  r_valid, r_data, r_last, r_id, r_resp,
    output r_ready
  );
endinterface

// File: rtl/nasti_sram_slave.sv
// NASTI slave backed by a word-wide RAM; independent read and write burst engines,
// one outstanding burst per direction, INCR/FIXED bursts (WRAP handled as INCR).
//
// state  | meaning
// R_IDLE | ar_ready high, waiting for a read address
// R_DATA | streaming read beats on R
// W_IDLE | aw_ready high, waiting for a write address
// W_DATA | accepting write beats on W
// W_RESP | presenting the write response on B
module nasti_sram_slave #(
  parameter int ADDR_WIDTH = 64,
  parameter int DATA_WIDTH = 64,
  parameter int ID_WIDTH   = 1,
  parameter int MEM_BYTES  = 4096
) (
  input logic         aclk,
  input logic         aresetn,
  nasti_channel.slave s
);
  localparam int STRB_W = DATA_WIDTH / 8;
  localparam int SHIFT  = $clog2(STRB_W);
  localparam int WORDS  = MEM_BYTES >> SHIFT;
  localparam int IDX_W  = $clog2(WORDS);
  localparam logic [1:0] BURST_FIXED = 2'b00;

  typedef logic [IDX_W-1:0] idx_t;
  typedef enum logic       {R_IDLE, R_DATA} r_state_e;
  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_e;

  logic [DATA_WIDTH-1:0] mem_q [WORDS];

  // Size fields and address bits outside the RAM window are deliberately ignored.
  logic unused_ok;
  assign unused_ok = ^{s.aw_size, s.ar_size, s.aw_addr, s.ar_addr};

  r_state_e              r_state_q, r_state_d;
  idx_t                  r_idx_q, r_idx_d;
  logic [7:0]            r_len_q, r_len_d;
  logic [7:0]            r_beat_q, r_beat_d;
  logic [ID_WIDTH-1:0]   r_id_q, r_id_d;
  logic                  r_fixed_q, r_fixed_d;
  logic [DATA_WIDTH-1:0] r_data_q, r_data_d;

  w_state_e              w_state_q, w_state_d;
  idx_t                  w_idx_q, w_idx_d;
  logic [7:0]            w_len_q, w_len_d;
  logic [7:0]            w_beat_q, w_beat_d;
  logic [ID_WIDTH-1:0]   w_id_q, w_id_d;
  logic                  w_fixed_q, w_fixed_d;
  logic                  w_err_q, w_err_d;
  logic                  w_fire;

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_state_q <= R_IDLE;
      r_idx_q   <= '0;
      r_len_q   <= '0;
      r_beat_q  <= '0;
      r_id_q    <= '0;
      r_fixed_q <= 1'b0;
      r_data_q  <= '0;
    end else begin
      r_state_q <= r_state_d;
      r_idx_q   <= r_idx_d;
      r_len_q   <= r_len_d;
      r_beat_q  <= r_beat_d;
      r_id_q    <= r_id_d;
      r_fixed_q <= r_fixed_d;
      r_data_q  <= r_data_d;
    end
  end

  always_comb begin
    r_state_d  = r_state_q;
    r_idx_d    = r_idx_q;
    r_len_d    = r_len_q;
    r_beat_d   = r_beat_q;
    r_id_d     = r_id_q;
    r_fixed_d  = r_fixed_q;
    r_data_d   = r_data_q;
    s.ar_ready = 1'b0;
    s.r_valid  = 1'b0;
    s.r_last   = 1'b0;
    case (r_state_q)
      R_IDLE: begin
        s.ar_ready = 1'b1;
        if (s.ar_valid) begin
          r_idx_d   = s.ar_addr[SHIFT +: IDX_W];
          r_len_d   = s.ar_len;
          r_id_d    = s.ar_id;
          r_fixed_d = (s.ar_burst == BURST_FIXED);
          r_beat_d  = '0;
          r_data_d  = mem_q[r_idx_d];
          r_state_d = R_DATA;
        end
      end
      R_DATA: begin
        s.r_valid = 1'b1;
        s.r_last  = (r_beat_q == r_len_q);
        if (s.r_ready) begin
          if (s.r_last) begin
            r_state_d = R_IDLE;
          end else begin
            // Prefetch the next word so a continuously-ready master gets one beat per cycle.
            r_beat_d = r_beat_q + 8'd1;
            r_idx_d  = r_fixed_q ? r_idx_q : r_idx_q + idx_t'(1);
            r_data_d = mem_q[r_idx_d];
          end
        end
      end
      default: r_state_d = R_IDLE;
    endcase
  end

  assign s.r_data = r_data_q;
  assign s.r_id   = r_id_q;
  assign s.r_resp = 2'b00;

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      w_state_q <= W_IDLE;
      w_idx_q   <= '0;
      w_len_q   <= '0;
      w_beat_q  <= '0;
      w_id_q    <= '0;
      w_fixed_q <= 1'b0;
      w_err_q   <= 1'b0;
    end else begin
      w_state_q <= w_state_d;
      w_idx_q   <= w_idx_d;
      w_len_q   <= w_len_d;
      w_beat_q  <= w_beat_d;
      w_id_q    <= w_id_d;
      w_fixed_q <= w_fixed_d;
      w_err_q   <= w_err_d;
    end
  end

  always_comb begin
    w_state_d  = w_state_q;
    w_idx_d    = w_idx_q;
    w_len_d    = w_len_q;
    w_beat_d   = w_beat_q;
    w_id_d     = w_id_q;
    w_fixed_d  = w_fixed_q;
    w_err_d    = w_err_q;
    s.aw_ready = 1'b0;
    s.w_ready  = 1'b0;
    s.b_valid  = 1'b0;
    case (w_state_q)
      W_IDLE: begin
        s.aw_ready = 1'b1;
        if (s.aw_valid) begin
          w_idx_d   = s.aw_addr[SHIFT +: IDX_W];
          w_len_d   = s.aw_len;
          w_id_d    = s.aw_id;
          w_fixed_d = (s.aw_burst == BURST_FIXED);
          w_beat_d  = '0;
          w_err_d   = 1'b0;
          w_state_d = W_DATA;
        end
      end
      W_DATA: begin
        s.w_ready = 1'b1;
        if (s.w_valid) begin
          // The burst length is authoritative; a misplaced w_last only flags an error.
          w_err_d  = w_err_q | (s.w_last != (w_beat_q == w_len_q));
          w_beat_d = w_beat_q + 8'd1;
          w_idx_d  = w_fixed_q ? w_idx_q : w_idx_q + idx_t'(1);
          if (w_beat_q == w_len_q) w_state_d = W_RESP;
        end
      end
      W_RESP: begin
        s.b_valid = 1'b1;
        if (s.b_ready) w_state_d = W_IDLE;
      end
      default: w_state_d = W_IDLE;
    endcase
  end

  assign w_fire   = (w_state_q == W_DATA) && s.w_valid;
  assign s.b_id   = w_id_q;
  assign s.b_resp = w_err_q ? 2'b10 : 2'b00;

  // RAM has no reset so contents survive aresetn.
  always_ff @(posedge aclk) begin
    if (w_fire) begin
      for (int i = 0; i < STRB_W; i++) begin
        if (s.w_strb[i]) mem_q[w_idx_q][8*i +: 8] <= s.w_data[8*i +: 8];
      end
    end
  end
endmodule

// File: tb/tb_nasti_sram_slave.sv
// Randomized bench for nasti_sram_slave against a byte-array memory model with
// burst address arithmetic done directly from the protocol rules.
module tb_nasti_sram_slave;
  localparam int ADDR_WIDTH = 64;
  localparam int DATA_WIDTH = 64;
  localparam int ID_WIDTH   = 1;
  localparam int MEM_BYTES  = 4096;
  localparam int WORDS      = MEM_BYTES / 8;
  localparam int TIMEOUT    = 2000;
  localparam logic [1:0] FIXED = 2'b00;
  localparam logic [1:0] INCR  = 2'b01;
  localparam logic [1:0] WRAP  = 2'b10;

  logic aclk    = 1'b0;
  logic aresetn = 1'b0;
  always #5 aclk = ~aclk;

  nasti_channel #(.ADDR_WIDTH(ADDR_WIDTH), .DATA_WIDTH(DATA_WIDTH), .ID_WIDTH(ID_WIDTH)) s_if ();

  nasti_sram_slave #(
    .ADDR_WIDTH(ADDR_WIDTH), .DATA_WIDTH(DATA_WIDTH), .ID_WIDTH(ID_WIDTH), .MEM_BYTES(MEM_BYTES)
  ) dut (
    .aclk    (aclk),
    .aresetn (aresetn),
    .s       (s_if)
  );

  int checks   = 0;
  int failures = 0;

  logic [7:0]  ref_bytes [MEM_BYTES];
  logic [63:0] wd [256];
  logic [7:0]  ws [256];

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic int word_at(input logic [63:0] addr, input int k, input logic [1:0] burst);
    int base;
    base = int'((addr >> 3) % WORDS);
    return (burst == FIXED) ? base : (base + k) % WORDS;
  endfunction

  function automatic logic [63:0] model_word(input int w);
    logic [63:0] v;
    for (int b = 0; b < 8; b++) v[8*b +: 8] = ref_bytes[w*8 + b];
    return v;
  endfunction

  task automatic model_write(input int w, input logic [63:0] d, input logic [7:0] st);
    for (int b = 0; b < 8; b++) if (st[b]) ref_bytes[w*8 + b] = d[8*b +: 8];
  endtask

  // w_last is driven only on beat lastpos; lastpos != len produces a protocol error.
  task automatic do_write(input logic [63:0] addr, input int len, input logic [1:0] burst,
                          input logic id, input int lastpos, input bit gaps);
    int   k, t;
    logic ok, exp_err;
    exp_err = 1'b0;
    @(posedge aclk); #1;
    s_if.aw_valid = 1'b1; s_if.aw_addr = addr; s_if.aw_len = len[7:0];
    s_if.aw_burst = burst; s_if.aw_id = id; s_if.aw_size = 3'd3;
    t = 0;
    do begin
      @(negedge aclk); ok = s_if.aw_ready;
      @(posedge aclk); #1; t++;
    end while (!ok && t < TIMEOUT);
    s_if.aw_valid = 1'b0;
    if (!ok) begin check_eq("aw_timeout", 64'd0, 64'd1); return; end
    k = 0; t = 0;
    while (k <= len && t < TIMEOUT) begin
      s_if.w_valid = gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
      s_if.w_data  = wd[k];
      s_if.w_strb  = ws[k];
      s_if.w_last  = (k == lastpos);
      @(negedge aclk);
      if (s_if.w_valid && s_if.w_ready) begin
        model_write(word_at(addr, k, burst), wd[k], ws[k]);
        exp_err |= ((k == lastpos) != (k == len));
        k++;
      end
      @(posedge aclk); #1; t++;
    end
    s_if.w_valid = 1'b0; s_if.w_last = 1'b0;
    check_eq("w_beats", 64'(k), 64'(len + 1));
    ok = 1'b0; t = 0;
    while (!ok && t < TIMEOUT) begin
      s_if.b_ready = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
      @(negedge aclk);
      if (s_if.b_valid && s_if.b_ready) begin
        ok = 1'b1;
        check_eq("b_id", 64'(s_if.b_id), 64'(id));
        check_eq("b_resp", 64'(s_if.b_resp), exp_err ? 64'd2 : 64'd0);
      end
      @(posedge aclk); #1; t++;
    end
    s_if.b_ready = 1'b0;
    if (!ok) check_eq("b_timeout", 64'd0, 64'd1);
  endtask

  // mode 0: always ready; 1: ready pattern 1,0,0,1; 2: random ready.
  task automatic do_read(input logic [63:0] addr, input int len, input logic [1:0] burst,
                         input logic id, input int mode);
    int   k, t;
    logic ok, rdy;
    @(posedge aclk); #1;
    s_if.ar_valid = 1'b1; s_if.ar_addr = addr; s_if.ar_len = len[7:0];
    s_if.ar_burst = burst; s_if.ar_id = id; s_if.ar_size = 3'd3;
    t = 0;
    do begin
      @(negedge aclk); ok = s_if.ar_ready;
      @(posedge aclk); #1; t++;
    end while (!ok && t < TIMEOUT);
    s_if.ar_valid = 1'b0;
    if (!ok) begin check_eq("ar_timeout", 64'd0, 64'd1); return; end
    k = 0; t = 0;
    while (k <= len && t < TIMEOUT) begin
      case (mode)
        0:       rdy = 1'b1;
        1:       rdy = (t % 4 == 0) || (t % 4 == 3);
        default: rdy = 1'($urandom_range(0, 1));
      endcase
      s_if.r_ready = rdy;
      @(negedge aclk);
      if (s_if.r_valid) begin
        // Checked on stalled cycles too: data must already show beat k and stay there.
        check_eq(rdy ? "r_data" : "r_stall_data", s_if.r_data, model_word(word_at(addr, k, burst)));
        check_eq("r_last", 64'(s_if.r_last), 64'(k == len));
        if (rdy) begin
          check_eq("r_id", 64'(s_if.r_id), 64'(id));
          check_eq("r_resp", 64'(s_if.r_resp), 64'd0);
          k++;
        end
      end
      @(posedge aclk); #1; t++;
    end
    s_if.r_ready = 1'b0;
    check_eq("r_beats", 64'(k), 64'(len + 1));
    @(negedge aclk);
    check_eq("r_end_valid", 64'(s_if.r_valid), 64'd0);
    check_eq("r_end_ar_ready", 64'(s_if.ar_ready), 64'd1);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] a;
    int          len;
    logic [1:0]  bt;

    s_if.aw_valid = 0; s_if.aw_addr = 0; s_if.aw_len = 0; s_if.aw_size = 0; s_if.aw_burst = 0; s_if.aw_id = 0;
    s_if.w_valid = 0; s_if.w_data = 0; s_if.w_strb = 0; s_if.w_last = 0; s_if.b_ready = 0;
    s_if.ar_valid = 0; s_if.ar_addr = 0; s_if.ar_len = 0; s_if.ar_size = 0; s_if.ar_burst = 0; s_if.ar_id = 0;
    s_if.r_ready = 0;

    repeat (3) @(posedge aclk);
    @(negedge aclk);
    check_eq("rst_ar_ready", 64'(s_if.ar_ready), 64'd1);
    check_eq("rst_aw_ready", 64'(s_if.aw_ready), 64'd1);
    check_eq("rst_w_ready",  64'(s_if.w_ready),  64'd0);
    check_eq("rst_r_valid",  64'(s_if.r_valid),  64'd0);
    check_eq("rst_b_valid",  64'(s_if.b_valid),  64'd0);
    check_eq("rst_r_last",   64'(s_if.r_last),   64'd0);
    @(posedge aclk); #1;
    aresetn = 1'b1;

    // Fill the whole RAM so every later read has a defined expected value.
    for (int h = 0; h < 2; h++) begin
      for (int k = 0; k < 256; k++) begin wd[k] = {$urandom, $urandom}; ws[k] = 8'hFF; end
      do_write(64'(h * 2048), 255, INCR, 1'b0, 255, 1'b0);
    end

    for (int k = 0; k < 4; k++) begin wd[k] = 64'hA0 + 64'(k); ws[k] = 8'hFF; end
    do_write(64'h100, 3, INCR, 1'b1, 3, 1'b0);
    do_read(64'h100, 3, INCR, 1'b1, 0);

    wd[0] = '1; ws[0] = 8'hFF;
    do_write(64'h40, 0, INCR, 1'b0, 0, 1'b0);
    wd[0] = 64'h1122334455667788; ws[0] = 8'h0F;
    do_write(64'h40, 0, INCR, 1'b0, 0, 1'b0);
    do_read(64'h40, 0, INCR, 1'b0, 0);

    do_read(64'h400, 15, INCR, 1'b1, 1);
    do_read(64'(MEM_BYTES - 16), 3, INCR, 1'b0, 0);
    do_read(64'(MEM_BYTES - 8), 2, WRAP, 1'b1, 2);

    for (int k = 0; k < 3; k++) begin wd[k] = {$urandom, $urandom}; ws[k] = 8'hFF; end
    do_write(64'h8, 2, FIXED, 1'b0, 2, 1'b0);
    do_read(64'h8, 0, INCR, 1'b0, 0);
    do_read(64'h0, 2, INCR, 1'b0, 0);

    for (int k = 0; k < 4; k++) begin wd[k] = {$urandom, $urandom}; ws[k] = 8'hFF; end
    do_write(64'h500, 3, INCR, 1'b1, 1, 1'b0);
    do_read(64'h500, 3, INCR, 1'b1, 0);

    // W presented with no AW in flight must be refused.
    @(posedge aclk); #1;
    s_if.w_valid = 1'b1; s_if.w_last = 1'b1; s_if.w_data = '1; s_if.w_strb = 8'hFF;
    for (int c = 0; c < 3; c++) begin
      @(negedge aclk);
      check_eq("w_early_ready", 64'(s_if.w_ready), 64'd0);
      @(posedge aclk); #1;
    end
    s_if.w_valid = 1'b0; s_if.w_last = 1'b0;

    for (int k = 0; k < 8; k++) begin wd[k] = {$urandom, $urandom}; ws[k] = 8'($urandom); end
    fork
      do_write(64'h200, 7, INCR, 1'b0, 7, 1'b1);
      do_read(64'h300, 7, INCR, 1'b1, 2);
    join
    do_read(64'h200, 7, INCR, 1'b0, 0);

    for (int n = 0; n < 20; n++) begin
      a   = {$urandom, $urandom};
      len = $urandom_range(0, 15);
      bt  = 2'($urandom_range(0, 2));
      for (int k = 0; k <= len; k++) begin wd[k] = {$urandom, $urandom}; ws[k] = 8'($urandom); end
      do_write(a, len, bt, 1'($urandom_range(0, 1)), len, 1'b1);
      do_read(a, len, bt, 1'($urandom_range(0, 1)), $urandom_range(0, 2));
    end

    // Reset in the middle of a long read burst.
    @(posedge aclk); #1;
    s_if.ar_valid = 1'b1; s_if.ar_addr = 64'h0; s_if.ar_len = 8'd15; s_if.ar_burst = INCR; s_if.ar_id = 1'b0;
    @(negedge aclk);
    check_eq("mid_ar_ready", 64'(s_if.ar_ready), 64'd1);
    @(posedge aclk); #1;
    s_if.ar_valid = 1'b0; s_if.r_ready = 1'b1;
    repeat (3) @(posedge aclk);
    @(negedge aclk);
    check_eq("mid_r_valid", 64'(s_if.r_valid), 64'd1);
    #1 aresetn = 1'b0;
    #1;
    check_eq("rst_mid_r_valid", 64'(s_if.r_valid), 64'd0);
    check_eq("rst_mid_r_last",  64'(s_if.r_last),  64'd0);
    s_if.r_ready = 1'b0;
    repeat (2) @(posedge aclk);
    #1 aresetn = 1'b1;
    @(negedge aclk);
    check_eq("post_rst_ar_ready", 64'(s_if.ar_ready), 64'd1);
    check_eq("post_rst_r_valid",  64'(s_if.r_valid),  64'd0);
    do_read(64'h100, 3, INCR, 1'b1, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
